// File: rtl/dio_pin_engine_pkg.sv
// dio_pin_engine shared definitions
// Mode codes, synchroniser depth and field-slicing helper
package dio_pkg;

    localparam logic [2:0] MODE_CONST0 = 3'd0;
    localparam logic [2:0] MODE_CONST1 = 3'd1;
    localparam logic [2:0] MODE_PASS   = 3'd2;
    localparam logic [2:0] MODE_INV    = 3'd3;
    localparam logic [2:0] MODE_AND    = 3'd4;
    localparam logic [2:0] MODE_OR     = 3'd5;
    localparam logic [2:0] MODE_DIV    = 3'd6;
    localparam logic [2:0] MODE_PULSE  = 3'd7;

    localparam int SYNC_STAGES = 2;

    // Pull field idx of width w out of a flattened bus (LSB = field 0)
    function automatic logic [15:0] get_field(
        input logic [255:0] bus,
        input int           idx,
        input int           w
    );
        logic [255:0] s;
        logic [255:0] m;
        s = bus >> (idx * w);
        m = (256'(1) << w) - 256'(1);
        return 16'(s & m);
    endfunction

endpackage

// File: rtl/dio_pin_engine_if.sv
// dio_pin_engine register-side bus
// Per-output configuration in, per-input status out
interface dio_pin_engine_if #(
    parameter int N_IN    = 8,
    parameter int N_OUT   = 8,
    parameter int SEL_W   = 4,
    parameter int PULSE_W = 8,
    parameter int COUNT_W = 16
);

    logic [3*N_OUT-1:0]     mode_cfg;
    logic [SEL_W*N_OUT-1:0] src_a_cfg;
    logic [SEL_W*N_OUT-1:0] src_b_cfg;
    logic [PULSE_W-1:0]     pulse_len;
    logic                   count_clr;
    logic [COUNT_W*N_IN-1:0] edge_count;
    logic [N_IN-1:0]        din_filt;

    modport master (
        output mode_cfg,
        output src_a_cfg,
        output src_b_cfg,
        output pulse_len,
        output count_clr,
        input  edge_count,
        input  din_filt
    );

    modport slave (
        input  mode_cfg,
        input  src_a_cfg,
        input  src_b_cfg,
        input  pulse_len,
        input  count_clr,
        output edge_count,
        output din_filt
    );

endinterface

// File: rtl/dio_in_filter.sv
// dio_in_filter: one input pin
// Two-flop synchroniser, optional debounce, rising-edge detect
module dio_in_filter
    import dio_pkg::*;
#(
    parameter int DEBOUNCE_LEN = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   synced;
    logic                   prev;

    assign synced = sync[SYNC_STAGES-1];

    // Metastability synchroniser for the asynchronous pin
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync <= '0;
        else        sync <= {sync[SYNC_STAGES-2:0], din};
    end

    generate
        if (DEBOUNCE_LEN == 0) begin : g_bypass
            // No filtering: register the synced level once
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) level <= 1'b0;
                else        level <= synced;
            end
        end else begin : g_debounce
            localparam int CW = $clog2(DEBOUNCE_LEN + 1);
            localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_LEN - 1);

            logic [CW-1:0] cnt;

            // Accept a new level only after it has held for the full window
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt   <= '0;
                    level <= 1'b0;
                end else if (synced != level) begin
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        level <= synced;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end else begin
                    cnt <= '0;
                end
            end
        end
    endgenerate

    // Previous filtered level for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev <= 1'b0;
        else        prev <= level;
    end

    assign rise = level & ~prev;

endmodule

// File: rtl/dio_pin_engine.sv
// dio_pin_engine: programmable digital-I/O pin processor
// Filtered inputs, edge counters, per-output mode muxes
module dio_pin_engine
    import dio_pkg::*;
#(
    parameter int N_IN         = 8,
    parameter int N_OUT        = 8,
    parameter int SEL_W        = 4,
    parameter int CNT_W        = 8,
    parameter int DEBOUNCE_LEN = 0,
    parameter int PULSE_W      = 8,
    parameter int COUNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_IN-1:0]  din,
    output logic [N_OUT-1:0] dout,
    dio_pin_engine_if.slave  bus
);

    localparam int PAD_W  = 2 ** SEL_W;
    localparam int DIV_IW = (CNT_W > 1) ? $clog2(CNT_W) : 1;

    logic [1:0]         rst_q;
    logic               rst_n;
    logic [N_IN-1:0]    level;
    logic [N_IN-1:0]    rise;
    logic [PAD_W-1:0]   level_pad;
    logic [PAD_W-1:0]   rise_pad;
    logic [CNT_W-1:0]   div_cnt;
    logic [COUNT_W-1:0] cnt_q [N_IN];

    // Asynchronous assert, synchronous release of the internal reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rst_q <= '0;
        else        rst_q <= {rst_q[0], 1'b1};
    end

    assign rst_n = rst_q[1];

    genvar gi;
    generate
        for (gi = 0; gi < N_IN; gi++) begin : g_in
            dio_in_filter #(
                .DEBOUNCE_LEN(DEBOUNCE_LEN)
            ) u_filter (
                .clk  (clk),
                .rst_n(rst_n),
                .din  (din[gi]),
                .level(level[gi]),
                .rise (rise[gi])
            );

            assign bus.edge_count[gi*COUNT_W +: COUNT_W] = cnt_q[gi];
        end
    endgenerate

    assign bus.din_filt = level;

    // Zero-padded views so out-of-range selects read 0
    always_comb begin
        level_pad = '0;
        rise_pad  = '0;
        level_pad[N_IN-1:0] = level;
        rise_pad[N_IN-1:0]  = rise;
    end

    // Free-running divider source
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) div_cnt <= '0;
        else        div_cnt <= div_cnt + 1'b1;
    end

    // Saturating rising-edge counters; clear dominates
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_IN; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < N_IN; i++) begin
                if (bus.count_clr)
                    cnt_q[i] <= '0;
                else if (rise[i] && (cnt_q[i] != '1))
                    cnt_q[i] <= cnt_q[i] + 1'b1;
            end
        end
    end

    genvar go;
    generate
        for (go = 0; go < N_OUT; go++) begin : g_out
            logic [2:0]         mode;
            logic [SEL_W-1:0]   sa;
            logic [SEL_W-1:0]   sb;
            logic               a;
            logic               b;
            logic               ra;
            logic [DIV_IW-1:0]  di;
            logic [PULSE_W-1:0] tmr;
            logic [PULSE_W-1:0] tmr_nx;
            logic               term;
            logic               out_q;

            // Decode this output's fields and operands
            always_comb begin
                mode = 3'(get_field(256'(bus.mode_cfg), go, 3));
                sa   = SEL_W'(get_field(256'(bus.src_a_cfg), go, SEL_W));
                sb   = SEL_W'(get_field(256'(bus.src_b_cfg), go, SEL_W));
                a    = level_pad[sa];
                b    = level_pad[sb];
                ra   = rise_pad[sa];
                di   = DIV_IW'(int'(sa) % CNT_W);
            end

            // One-shot timer; idle outside pulse mode
            always_comb begin
                tmr_nx = '0;
                if (mode == MODE_PULSE) begin
                    if (ra)
                        tmr_nx = bus.pulse_len;
                    else if (tmr != '0)
                        tmr_nx = tmr - 1'b1;
                end
            end

            // Select the output term for the current mode
            always_comb begin
                term = 1'b0;
                unique case (mode)
                    MODE_CONST0: term = 1'b0;
                    MODE_CONST1: term = 1'b1;
                    MODE_PASS:   term = a;
                    MODE_INV:    term = ~a;
                    MODE_AND:    term = a & b;
                    MODE_OR:     term = a | b;
                    MODE_DIV:    term = div_cnt[di];
                    MODE_PULSE:  term = (tmr_nx != '0);
                    default:     term = 1'b0;
                endcase
            end

            // Register timer and pin output
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    tmr   <= '0;
                    out_q <= 1'b0;
                end else begin
                    tmr   <= tmr_nx;
                    out_q <= term;
                end
            end

            assign dout[go] = out_q;
        end
    endgenerate

endmodule

// File: doc/dio_pin_engine.md
Name: dio_pin_engine

Overview:
- Parametrised digital-I/O processor for an MCC slot wired to the DIO header.
- Synchronises and optionally debounces N_IN input pins, and counts rising edges per input.
- Drives N_OUT output pins. Each output has its own runtime mode: constant, pass, invert, AND, OR, divided clock or one-shot pulse.
- Replaces fixed per-pin wiring with register-programmable routing.

Parameters:
N_IN, 8, number of input pins (1..16)
N_OUT, 8, number of output pins (1..16)
SEL_W, 4, width of each source-select field; must satisfy 2**SEL_W >= N_IN
CNT_W, 8, width of free-running divider counter
DEBOUNCE_LEN, 0, consecutive stable cycles required before a filtered input changes; 0 = filter bypassed
PULSE_W, 8, width of one-shot pulse length
COUNT_W, 16, width of each edge counter

Ports:
clk  in  1  core clock
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
din  in  N_IN  raw pin inputs, asynchronous to clk
dout  out  N_OUT  registered pin outputs
mode_cfg  in  3*N_OUT  per-output mode, 3 bits per output
src_a_cfg  in  SEL_W*N_OUT  per-output source A index
src_b_cfg  in  SEL_W*N_OUT  per-output source B index
pulse_len  in  PULSE_W  one-shot length in cycles, shared by all outputs
count_clr  in  1  synchronous clear of all edge counters
edge_count  out  COUNT_W*N_IN  per-input rising-edge counts
din_filt  out  N_IN  filtered input levels, for status readback

Behaviour:
Reset:
- Asynchronous assert, synchronous release.
- While reset=0, all of the following are 0: sync flops, filter state, din_filt, div counter, pulse timers, edge_count, dout.

Input path, per pin:
- Two-flop synchroniser.
- DEBOUNCE_LEN=0: din_filt is the second sync flop registered once. Latency from din to din_filt is 3 cycles.
- DEBOUNCE_LEN>0: din_filt takes the synced value only after that value has differed from din_filt for DEBOUNCE_LEN consecutive cycles. Any bounce restarts the stability counter.

Rising edges and counters:
- Rising edge = din_filt is 1 this cycle and was 0 the previous cycle.
- edge_count[i] increments on each rising edge of pin i and saturates at all-ones.
- count_clr=1 forces all counters to 0. If an edge occurs in the same cycle, the result is still 0.

Divider:
- div_cnt is a CNT_W-bit free-running counter incrementing every cycle and wrapping to 0.

Output modes (dout registered, one cycle after the selected term):
- Operand A = din_filt[src_a]; operand B = din_filt[src_b].
- Any source index >= N_IN reads as 0.
- 0 CONST0: 0
- 1 CONST1: 1
- 2 PASS: A
- 3 INV: not A
- 4 AND: A and B
- 5 OR: A or B
- 6 DIV: div_cnt[src_a mod CNT_W]. Bit k toggles at clk/2^(k+1).
- 7 PULSE: on each rising edge of source A, load the timer with pulse_len. dout is 1 while timer > 0; the timer decrements each cycle.
  - A new edge while active reloads the timer (retrigger).
  - pulse_len=0 produces no pulse.
  - A single edge yields exactly pulse_len high cycles, starting the cycle after the edge is detected.

Configuration changes:
- Changes to mode_cfg, src_a_cfg or src_b_cfg take effect on the next clock edge. No combinational path to dout.
- Leaving mode 7 clears that output's timer.

Decomposition:
- Package dio_pkg holds:
  - 3-bit mode constants MODE_CONST0..MODE_PULSE
  - the sync stage count (2)
  - helper function for slicing flattened per-output fields
- Sub-module dio_in_filter: one per input, instantiated by generate. It contains the synchroniser, debounce counter and edge detect, and outputs level and rise.
- Output muxes, pulse timers, div_cnt and edge counters stay in dio_pin_engine.

Test Plan:
- Reset: reset=0 with random din/config -> dout, edge_count and din_filt all 0. Release reset, out0 mode=1 -> dout[0]=1 three cycles later (config cycle + 1).
- PASS/INV (DEBOUNCE_LEN=0): out0 PASS src_a=3, out1 INV src_a=3; step din[3] 0->1 -> din_filt[3]=1 after 3 cycles, dout[0]=1 and dout[1]=0 one cycle later. Check source index 12 with N_IN=8 -> reads 0.
- Debounce (DEBOUNCE_LEN=4): glitch din[0] high for 3 cycles -> din_filt[0] stays 0. Hold high for 6 cycles -> din_filt rises; edge_count[0]=1.
- DIV: out2 DIV src_a=1 -> dout[2] period 4 cycles, 50% duty. src_a=9 with CNT_W=8 -> uses bit 1.
- PULSE: pulse_len=5, single edge -> exactly 5 high cycles. Second edge 2 cycles into the pulse -> high 7 cycles total. pulse_len=0 -> no pulse.
- Counters: 70000 edges with COUNT_W=16 -> saturates at 65535. count_clr coincident with an edge -> 0. Assert reset mid-pulse -> dout=0 immediately (asynchronous).
